gg_vectoring: RTL and testbench
===============================

# gg_vectoring

Givens-generation cell for the QR systolic array: the diagonal-cell counterpart that produces the 12-bit micro-rotation direction words consumed by the rotation cells. It holds the running diagonal element r, annihilates each incoming column element with a 12-iteration vectoring CORDIC, and emits one direction word per element. At column end it emits the gain-compensated r. Throughput is one element per clock.

## Interface
- DATA_W, 13: signed sample width on data_in/data_out
- N_ITER, 12: CORDIC iterations; also the di_out width
- SHIFT_VALID, 4: fractional guard bits added on entry and removed on exit
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  data_in, first and last_end_in are meaningful this cycle
- data_in  in  DATA_W  signed column element
- first  in  1  element opens a new column; it becomes the initial r
- last_end_in  in  1  element closes the column
- out_valid  out  1  outputs below are meaningful
- di_out  out  N_ITER  direction bits; bit i is iteration i (1 = signs of x_i and y_i differ)
- data_out  out  DATA_W  signed; residual y on normal elements, final r on last element
- first_out  out  1  registered copy of first
- last_out  out  1  registered copy of last_end_in

## Operation
- Internal width is 26 bits, signed. The entry value is data_in <<< SHIFT_VALID.
- Two-state FSM.
  - IDLE: no open column.
  - ACC: r holds a valid value.
- Valid element with first=1, in either state:
  - r <= data_in<<<4.
  - di_out = 0; data_out = data_in.
  - Next state is ACC, or IDLE if last_end_in=1 in the same cycle.
- Valid element with first=0 in ACC:
  - Set x0 = r and y0 = data_in<<<4.
  - For each iteration i, compute d_i = sign(x_i) XOR sign(y_i).
    - d_i = 1: x_{i+1} = x_i − (y_i>>>i), y_{i+1} = y_i + (x_i>>>i).
    - d_i = 0: x_{i+1} = x_i + (y_i>>>i), y_{i+1} = y_i − (x_i>>>i).
  - r <= (x_12 × 155) >>> 8, which applies gain compensation k = 155/256.
  - di_out = {d_11..d_0}; data_out = y_12 >>> 4.
- If last_end_in=1 on a non-first element:
  - data_out = new r >>> 4 instead of the residual.
  - State returns to IDLE.
- r keeps the sign of the opening element; no quadrant pre-rotation is applied.
- Valid element with first=0 in IDLE: it is treated as first.
- in_valid=0 is a bubble:
  - No state or r change.
  - out_valid=0; data_out/di_out are held at their previous values.
- Arithmetic shifts are used throughout. Intermediate values never exceed 26 bits for 13-bit inputs.

## Timing
- Latency is 1 cycle: inputs are sampled at edge N, and all outputs are registered and valid after edge N.
- The r feedback completes in one cycle, so back-to-back valid elements are accepted every cycle.
- Reset values: out_valid, di_out, data_out, first_out and last_out are all 0; r = 0; FSM = IDLE.
- Reset mid-column discards r. The next valid element opens a new column whether or not first is set.
- first and last_end_in together give a single-element column: the element passes through unchanged and last_out=1.

## Configuration
- GG_SAT_EN defined: data_out saturates to the range [−2^(DATA_W−1), 2^(DATA_W−1)−1] after the >>>4.
- GG_SAT_EN undefined: data_out is the plain two's-complement truncation, which wraps.
- r is always kept at full 26 bits regardless of the macro.

## Structure
- Package gg_pkg holds:
  - BIT_SIZE = 26, SHIFT_VALID = 4, N_ITER = 12.
  - K_GAIN = 9'sd155 and K_SHIFT = 8.
  - The FSM state enum {IDLE, ACC}.
- Sub-module gg_micro_stage implements one vectoring iteration.
  - Inputs: x, y, iteration index (parameter).
  - Outputs: x', y', d.
  - It is instantiated N_ITER times in a generate chain.

## Test plan
- Basic vectoring: first 300, then 400 with last.
  - di_out for 400 has bit0 = 0.
  - Final data_out = 500 ± 2; last_out=1.
- Sign rule: first 100, then −100.
  - di_out bit0 = 1; residual |data_out| ≤ 2.
- Single-element column: first+last with −77.
  - Next cycle: data_out = −77, di_out = 0, last_out = 1, first_out = 1.
- Bubbles: first 300, then in_valid=0 for 3 cycles, then 400 with last.
  - The result matches the basic vectoring case.
  - out_valid is low during the bubbles.
- Saturation: first 4000, then 4000 with last.
  - With GG_SAT_EN: data_out = 4095.
  - Without GG_SAT_EN: data_out = 5657 − 8192 = −2535 (±3).
- Reset mid-column: first 300, assert reset, release, then 400 with no first.
  - All outputs are 0 during reset.
  - 400 is treated as opening a new column: data_out = 400, di_out = 0.

Source files
------------

// File: rtl/gg_pkg.sv
// Shared constants and types for the Givens-generation (vectoring) cell.
package gg_pkg;

    localparam int BIT_SIZE    = 26;
    localparam int SHIFT_VALID = 4;
    localparam int N_ITER      = 12;

    // Gain compensation k = 155/256 ~ 1/1.6468
    localparam logic signed [8:0] K_GAIN  = 9'sd155;
    localparam int                K_SHIFT = 8;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } gg_state_e;

endpackage

// File: rtl/gg_vectoring_if.sv
// Element stream into the vectoring cell and direction/result stream out of it.
interface gg_vectoring_if #(
    parameter int DATA_W = 13,
    parameter int N_ITER = 12
);
    logic                     in_valid;
    logic signed [DATA_W-1:0] data_in;
    logic                     first;
    logic                     last_end_in;

    logic                     out_valid;
    logic        [N_ITER-1:0] di_out;
    logic signed [DATA_W-1:0] data_out;
    logic                     first_out;
    logic                     last_out;

    modport master (
        output in_valid, data_in, first, last_end_in,
        input  out_valid, di_out, data_out, first_out, last_out
    );

    modport slave (
        input  in_valid, data_in, first, last_end_in,
        output out_valid, di_out, data_out, first_out, last_out
    );
endinterface

// File: rtl/gg_micro_stage.sv
// One vectoring CORDIC micro-rotation: drives y toward zero.
module gg_micro_stage
    import gg_pkg::*;
#(
    parameter int ITER = 0
) (
    input  logic signed [BIT_SIZE-1:0] x_i,
    input  logic signed [BIT_SIZE-1:0] y_i,
    output logic signed [BIT_SIZE-1:0] x_o,
    output logic signed [BIT_SIZE-1:0] y_o,
    output logic                       d
);
    logic signed [BIT_SIZE-1:0] x_sh;
    logic signed [BIT_SIZE-1:0] y_sh;

    assign x_sh = x_i >>> ITER;
    assign y_sh = y_i >>> ITER;
    // Differing signs mean y lies on the far side of the x axis from x
    assign d    = x_i[BIT_SIZE-1] ^ y_i[BIT_SIZE-1];

    // Rotate in the direction that reduces |y|
    always_comb begin
        if (d) begin
            x_o = x_i - y_sh;
            y_o = y_i + x_sh;
        end else begin
            x_o = x_i + y_sh;
            y_o = y_i - x_sh;
        end
    end
endmodule

// File: rtl/gg_vectoring.sv
// Givens-generation diagonal cell: running r, 12-stage vectoring CORDIC,
// one direction word per element, gain-compensated r at column end.
// Optional: define GG_SAT_EN to saturate data_out instead of wrapping.
module gg_vectoring
    import gg_pkg::*;
#(
    parameter int DATA_W      = 13,
    parameter int N_ITER      = 12,
    parameter int SHIFT_VALID = 4
) (
    input  logic           clk,
    input  logic           reset,
    gg_vectoring_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'(IDLE);
    localparam logic [0:0] S_ACC  = 1'(ACC);
    localparam int         PW     = BIT_SIZE - SHIFT_VALID;

    logic [0:0]                 state;
    logic signed [BIT_SIZE-1:0] r;
    logic signed [BIT_SIZE-1:0] y_in;
    logic signed [BIT_SIZE-1:0] xs [0:N_ITER];
    logic signed [BIT_SIZE-1:0] ys [0:N_ITER];
    logic        [N_ITER-1:0]   d;
    logic signed [BIT_SIZE+8:0] prod;
    logic signed [BIT_SIZE-1:0] r_new;
    logic signed [BIT_SIZE-1:0] sel;
    logic signed [PW-1:0]       pre;
    logic signed [DATA_W-1:0]   res;
    logic                       open_col;
    logic                       unused_bits;

    assign y_in  = {{(BIT_SIZE-DATA_W-SHIFT_VALID){bus.data_in[DATA_W-1]}},
                    bus.data_in, {SHIFT_VALID{1'b0}}};
    assign xs[0] = r;
    assign ys[0] = y_in;

    genvar gi;
    generate
        for (gi = 0; gi < N_ITER; gi++) begin : g_stage
            gg_micro_stage #(.ITER(gi)) u_stage (
                .x_i (xs[gi]),
                .y_i (ys[gi]),
                .x_o (xs[gi+1]),
                .y_o (ys[gi+1]),
                .d   (d[gi])
            );
        end
    endgenerate

    assign prod  = xs[N_ITER] * K_GAIN;
    assign r_new = prod[BIT_SIZE+K_SHIFT-1:K_SHIFT];
    assign sel   = bus.last_end_in ? r_new : ys[N_ITER];
    assign pre   = sel[BIT_SIZE-1:SHIFT_VALID];
    // A stray non-first element with no open column starts one
    assign open_col = bus.first || (state == S_IDLE);

    // Scale back to sample width: clamp or wrap depending on build
`ifdef GG_SAT_EN
    localparam logic signed [PW-1:0] SAT_HI = PW'((1 << (DATA_W-1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO = PW'(-(1 << (DATA_W-1)));
    always_comb begin
        res = pre[DATA_W-1:0];
        if (pre > SAT_HI)      res = SAT_HI[DATA_W-1:0];
        else if (pre < SAT_LO) res = SAT_LO[DATA_W-1:0];
    end
    assign unused_bits = ^{prod[BIT_SIZE+8], prod[K_SHIFT-1:0], sel[SHIFT_VALID-1:0]};
`else
    always_comb begin
        res = pre[DATA_W-1:0];
    end
    assign unused_bits = ^{prod[BIT_SIZE+8], prod[K_SHIFT-1:0], sel[SHIFT_VALID-1:0],
                           pre[PW-1:DATA_W]};
`endif

    // Column state, running r and registered outputs; bubbles hold everything
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            r             <= '0;
            bus.out_valid <= 1'b0;
            bus.di_out    <= '0;
            bus.data_out  <= '0;
            bus.first_out <= 1'b0;
            bus.last_out  <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.first_out <= bus.first;
                bus.last_out  <= bus.last_end_in;
                state         <= bus.last_end_in ? S_IDLE : S_ACC;
                if (open_col) begin
                    r            <= y_in;
                    bus.di_out   <= '0;
                    bus.data_out <= bus.data_in;
                end else begin
                    r            <= r_new;
                    bus.di_out   <= d;
                    bus.data_out <= res;
                end
            end
        end
    end
endmodule

// File: tb/tb_gg_vectoring.sv
// Self-checking bench for gg_vectoring: reference model feeds a scoreboard
// queue; outputs are popped and compared one cycle after each valid element.
module tb_gg_vectoring;
    localparam int DATA_W = 13;
    localparam int N_ITER = 12;

    typedef struct {
        longint data;
        longint di;
        bit     first;
        bit     last;
    } exp_t;

    logic clk;
    logic reset;
    gg_vectoring_if #(.DATA_W(DATA_W), .N_ITER(N_ITER)) bus ();

    gg_vectoring #(.DATA_W(DATA_W), .N_ITER(N_ITER), .SHIFT_VALID(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_tot  = 0;
    exp_t   sb [$];
    longint m_r    = 0;
    bit     m_acc  = 0;
    longint last_data = 0;
    longint last_di   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tot++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Spec-level reference: vectoring CORDIC on wide integers
    function automatic exp_t model(input longint din, input bit f, input bit l);
        exp_t   e;
        longint x, y, xn, yn, rn, o;
        e.first = f;
        e.last  = l;
        e.di    = 0;
        if (f || !m_acc) begin
            m_r    = din * 16;
            e.data = din;
        end else begin
            x = m_r;
            y = din * 16;
            for (int i = 0; i < N_ITER; i++) begin
                if ((x < 0) != (y < 0)) begin
                    e.di = e.di | (longint'(1) << i);
                    xn = x - (y >>> i);
                    yn = y + (x >>> i);
                end else begin
                    xn = x + (y >>> i);
                    yn = y - (x >>> i);
                end
                x = xn;
                y = yn;
            end
            rn  = (x * 155) >>> 8;
            m_r = rn;
            o   = (l ? rn : y) >>> 4;
`ifdef GG_SAT_EN
            if (o > 4095) o = 4095;
            if (o < -4096) o = -4096;
`else
            o = o & 64'h1fff;
            if (o >= 4096) o = o - 8192;
`endif
            e.data = o;
        end
        m_acc = !l;
        return e;
    endfunction

    // Drive one cycle of input, then compare against the scoreboard
    task automatic step(input bit v, input longint din, input bit f, input bit l);
        exp_t e;
        @(negedge clk);
        bus.in_valid    = v;
        bus.data_in     = DATA_W'(din);
        bus.first       = f;
        bus.last_end_in = l;
        if (v) sb.push_back(model(din, f, l));
        @(posedge clk);
        #1;
        chk("out_valid", longint'(bus.out_valid), longint'(v));
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("data_out",  longint'($signed(bus.data_out)), e.data);
                chk("di_out",    longint'(bus.di_out), e.di);
                chk("first_out", longint'(bus.first_out), longint'(e.first));
                chk("last_out",  longint'(bus.last_out), longint'(e.last));
                last_data = e.data;
                last_di   = e.di;
            end
        end else begin
            chk("hold_data", longint'($signed(bus.data_out)), last_data);
            chk("hold_di",   longint'(bus.di_out), last_di);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_out_valid", longint'(bus.out_valid), 0);
        chk("rst_di_out",    longint'(bus.di_out), 0);
        chk("rst_data_out",  longint'($signed(bus.data_out)), 0);
        chk("rst_first_out", longint'(bus.first_out), 0);
        chk("rst_last_out",  longint'(bus.last_out), 0);
    endtask

    initial begin
        longint v;
        bus.in_valid    = 1'b0;
        bus.data_in     = '0;
        bus.first       = 1'b0;
        bus.last_end_in = 1'b0;
        reset = 1'b0;
        #23;
        chk_reset_outs();
        @(negedge clk);
        reset = 1'b1;

        // Basic vectoring
        step(1, 300, 1, 0);
        step(1, 400, 0, 1);
        chk("basic_d0", longint'(bus.di_out[0]), 0);
        chk("basic_last", longint'(bus.last_out), 1);

        // Sign rule
        step(1, 100, 1, 0);
        step(1, -100, 0, 0);
        chk("sign_d0", longint'(bus.di_out[0]), 1);
        v = longint'($signed(bus.data_out));
        chk("sign_resid_small", longint'(v >= -2 && v <= 2), 1);
        step(1, 50, 0, 1);

        // Single-element column
        step(1, -77, 1, 1);
        chk("single_data", longint'($signed(bus.data_out)), -77);
        chk("single_first", longint'(bus.first_out), 1);

        // Bubbles inside a column
        step(1, 300, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        step(1, 400, 0, 1);

        // Large inputs: saturate or wrap depending on build
        step(1, 4000, 1, 0);
        step(1, 4000, 0, 1);
`ifdef GG_SAT_EN
        chk("sat_data", longint'($signed(bus.data_out)), 4095);
`else
        chk("wrap_neg", longint'(bus.data_out[DATA_W-1]), 1);
`endif

        // Non-first element with no open column opens one
        step(1, 123, 0, 0);
        step(1, -45, 0, 1);

        // Random columns
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 5; k++) begin
                v = longint'($urandom_range(0, 4000)) - 2000;
                step(1, v, k == 0, k == 4);
                if ($urandom_range(0, 2) == 0) step(0, 0, 0, 0);
            end
        end

        // Reset mid-column
        step(1, 300, 1, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_reset_outs();
        sb.delete();
        m_r = 0;
        m_acc = 0;
        last_data = 0;
        last_di = 0;
        @(negedge clk);
        reset = 1'b1;
        step(1, 400, 0, 0);
        chk("rst_open_data", longint'($signed(bus.data_out)), 400);
        chk("rst_open_di", longint'(bus.di_out), 0);
        step(1, 300, 0, 1);

        chk("sb_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
